// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the CPU-side 8259 INTA master.
// Holds the INTA state enum, CALL opcode and pulse counts per CPU mode.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PULSE_LOW,
    GAP,
    DELIVER
  } inta_state_t;

  localparam logic [7:0] PIC_CALL_OPCODE = 8'hCD;
  localparam logic [1:0] PIC_PULSES_8086 = 2'd2;
  localparam logic [1:0] PIC_PULSES_8080 = 2'd3;

  function automatic int pic_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic_interrupt_acknowledge_master_timer.sv
// pic_inta_pulse_timer: down-counter timing INTA low and gap phases.
// Ports: clock, reset (sync), load/load_value (start phase), done (count==0).
module pic_inta_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/pic_interrupt_acknowledge_master.sv
// pic_interrupt_acknowledge_master: runs the INTA pulse train for an 8259,
// captures the bus bytes and hands vector / CALL address to the CPU.
// Ports: clock, reset (sync, high), interrupt_enable, interrupt_to_cpu,
//   data_bus_in[7:0], interrupt_acknowledge_n, busy, vector[7:0],
//   call_address[15:0], call_opcode_error, vector_valid, vector_ready.
module pic_interrupt_acknowledge_master
  import pic_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int MODE_8080       = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_enable,
  input  logic        interrupt_to_cpu,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic [7:0]  vector,
  output logic [15:0] call_address,
  output logic        call_opcode_error,
  output logic        vector_valid,
  input  logic        vector_ready
);

  localparam int CW =
    $clog2(pic_max(INTA_LOW_CYCLES, INTA_GAP_CYCLES) + 1);
  localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES - 1);
  localparam logic [1:0] LAST_IDX = (MODE_8080 != 0)
    ? PIC_PULSES_8080 - 2'd1
    : PIC_PULSES_8086 - 2'd1;

  inta_state_t   state_q;
  inta_state_t   state_d;
  logic [1:0]    pulse_idx_q;
  logic [7:0]    byte0_q;
  logic [7:0]    byte1_q;
  logic          tmr_load;
  logic [CW-1:0] tmr_value;
  logic          tmr_done;
  logic          pulse_end;
  logic          last_end;

  pic_inta_pulse_timer #(
    .W(CW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // All strobes decode straight from the state register.
  assign interrupt_acknowledge_n = (state_q != PULSE_LOW);
  assign busy = (state_q == PULSE_LOW) || (state_q == GAP) ||
                (state_q == DELIVER);
  assign vector_valid = (state_q == DELIVER);
  assign last_end = pulse_end && (pulse_idx_q == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    pulse_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (interrupt_to_cpu && interrupt_enable && !vector_valid) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (interrupt_to_cpu && interrupt_enable) begin
          state_d   = PULSE_LOW;
          tmr_load  = 1'b1;
          tmr_value = LOW_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE_LOW: begin
        if (tmr_done) begin
          pulse_end = 1'b1;
          if (pulse_idx_q == LAST_IDX) begin
            state_d = DELIVER;
          end else begin
            state_d   = GAP;
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d   = PULSE_LOW;
          tmr_load  = 1'b1;
          tmr_value = LOW_LOAD;
        end
      end
      DELIVER: begin
        if (vector_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Early bytes are staged so the visible outputs only change on the
  // edge that raises vector_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      pulse_idx_q       <= '0;
      byte0_q           <= '0;
      byte1_q           <= '0;
      vector            <= '0;
      call_address      <= '0;
      call_opcode_error <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        pulse_idx_q <= '0;
      end else if (pulse_end && !last_end) begin
        pulse_idx_q <= pulse_idx_q + 2'd1;
      end
      if (pulse_end && pulse_idx_q == 2'd0) begin
        byte0_q <= data_bus_in;
      end
      if (pulse_end && pulse_idx_q == 2'd1) begin
        byte1_q <= data_bus_in;
      end
      if (last_end) begin
        if (MODE_8080 != 0) begin
          vector            <= byte0_q;
          call_address      <= {data_bus_in, byte1_q};
          call_opcode_error <= (byte0_q != PIC_CALL_OPCODE);
        end else begin
          vector            <= data_bus_in;
          call_address      <= '0;
          call_opcode_error <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_interrupt_acknowledge_master.sv
// tb_pic_interrupt_acknowledge_master: drives an 8086 and an 8080 instance
// with a small PIC bus stub; results go through a scoreboard queue.
module tb_pic_interrupt_acknowledge_master;

  typedef struct packed {
    logic [7:0]  vec;
    logic [15:0] addr;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        interrupt_enable;
  logic        vector_ready;
  logic [7:0]  data_bus_in = 8'h00;
  logic        int86, int80;
  logic        inta86, busy86, err86, v86;
  logic        inta80, busy80, err80, v80;
  logic [7:0]  vec86, vec80;
  logic [15:0] addr86, addr80;

  logic [7:0]  pic_bytes [3];
  exp_t        q86 [$];
  exp_t        q80 [$];
  exp_t        e86, e80;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pc = 0;
  bit          prev_inta = 1'b1;
  bit          saw;

  always #5 clock = ~clock;

  pic_interrupt_acknowledge_master u_dut86 (
    .clock                   (clock),
    .reset                   (reset),
    .interrupt_enable        (interrupt_enable),
    .interrupt_to_cpu        (int86),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (inta86),
    .busy                    (busy86),
    .vector                  (vec86),
    .call_address            (addr86),
    .call_opcode_error       (err86),
    .vector_valid            (v86),
    .vector_ready            (vector_ready)
  );

  pic_interrupt_acknowledge_master #(
    .MODE_8080(1)
  ) u_dut80 (
    .clock                   (clock),
    .reset                   (reset),
    .interrupt_enable        (interrupt_enable),
    .interrupt_to_cpu        (int80),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (inta80),
    .busy                    (busy80),
    .vector                  (vec80),
    .call_address            (addr80),
    .call_opcode_error       (err80),
    .vector_valid            (v80),
    .vector_ready            (vector_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // PIC stub: puts byte N on the bus when the Nth INTA pulse falls.
  always @(negedge clock) begin
    if (!(busy86 || busy80)) begin
      pc = 0;
    end else if (prev_inta && !(inta86 && inta80)) begin
      if (pc < 3) data_bus_in = pic_bytes[pc];
      pc = pc + 1;
    end
    prev_inta = inta86 && inta80;
  end

  // Scoreboard: compare every accepted result against the queue head.
  always @(negedge clock) begin
    #1;
    if (!reset && vector_ready) begin
      if (v86) begin
        if (q86.size() == 0) begin
          chk("sb86_unexpected", 32'(q86.size()), 1);
        end else begin
          e86 = q86.pop_front();
          chk("sb86_vector", 32'(vec86), 32'(e86.vec));
          chk("sb86_addr", 32'(addr86), 32'(e86.addr));
          chk("sb86_err", 32'(err86), 32'(e86.err));
        end
      end
      if (v80) begin
        if (q80.size() == 0) begin
          chk("sb80_unexpected", 32'(q80.size()), 1);
        end else begin
          e80 = q80.pop_front();
          chk("sb80_vector", 32'(vec80), 32'(e80.vec));
          chk("sb80_addr", 32'(addr80), 32'(e80.addr));
          chk("sb80_err", 32'(err80), 32'(e80.err));
        end
      end
    end
  end

  task automatic wait_for(input int sel, input int budget,
                          input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      case (sel)
        0: hit = v86;
        1: hit = !busy86;
        2: hit = v80;
        3: hit = !busy80;
        4: hit = busy80;
        default: hit = 1'b1;
      endcase
    end
    chk(tag, 32'(hit), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    interrupt_enable = 1'b0;
    vector_ready = 1'b0;
    int86 = 1'b0;
    int80 = 1'b0;
    pic_bytes[0] = 8'hFF;
    pic_bytes[1] = 8'hFF;
    pic_bytes[2] = 8'hFF;
    repeat (3) @(negedge clock);
    chk("rst_inta86", 32'(inta86), 1);
    chk("rst_busy86", 32'(busy86), 0);
    chk("rst_valid86", 32'(v86), 0);
    chk("rst_vector86", 32'(vec86), 0);
    chk("rst_addr86", 32'(addr86), 0);
    chk("rst_err86", 32'(err86), 0);
    chk("rst_inta80", 32'(inta80), 1);
    chk("rst_valid80", 32'(v80), 0);
    reset = 1'b0;
    @(negedge clock);

    // 8086 basic sequence with exact latency; INT drop mid-sequence
    interrupt_enable = 1'b1;
    pic_bytes[1] = 8'h43;
    q86.push_back('{vec: 8'h43, addr: 16'h0000, err: 1'b0});
    int86 = 1'b1;
    @(negedge clock);
    chk("t1_n1_inta", 32'(inta86), 1);
    chk("t1_n1_busy", 32'(busy86), 0);
    @(negedge clock);
    chk("t1_n2_inta", 32'(inta86), 0);
    chk("t1_n2_busy", 32'(busy86), 1);
    int86 = 1'b0;
    @(negedge clock);
    chk("t1_n3_inta", 32'(inta86), 0);
    @(negedge clock);
    chk("t1_n4_gap", 32'(inta86), 1);
    @(negedge clock);
    chk("t1_n5_gap", 32'(inta86), 1);
    @(negedge clock);
    chk("t1_n6_inta", 32'(inta86), 0);
    @(negedge clock);
    chk("t1_n7_inta", 32'(inta86), 0);
    chk("t1_n7_valid", 32'(v86), 0);
    @(negedge clock);
    chk("t1_n8_valid", 32'(v86), 1);
    chk("t1_n8_inta", 32'(inta86), 1);
    chk("t1_n8_busy", 32'(busy86), 1);
    vector_ready = 1'b1;
    @(negedge clock);
    chk("t1_valid_drop", 32'(v86), 0);
    chk("t1_busy_drop", 32'(busy86), 0);

    // one-edge INT glitch must be filtered
    @(negedge clock);
    int86 = 1'b1;
    @(negedge clock);
    int86 = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (!inta86 || busy86) saw = 1'b1;
    end
    chk("glitch_no_pulse", 32'(saw), 0);

    // enable gating
    interrupt_enable = 1'b0;
    int86 = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (!inta86) saw = 1'b1;
    end
    chk("gate_no_pulse", 32'(saw), 0);
    pic_bytes[1] = 8'h21;
    q86.push_back('{vec: 8'h21, addr: 16'h0000, err: 1'b0});
    interrupt_enable = 1'b1;
    @(negedge clock);
    chk("gate_n1_inta", 32'(inta86), 1);
    @(negedge clock);
    chk("gate_n2_inta", 32'(inta86), 0);
    int86 = 1'b0;
    wait_for(1, 20, "gate_done");

    // backpressure with INT held high
    @(negedge clock);
    vector_ready = 1'b0;
    pic_bytes[1] = 8'h5A;
    q86.push_back('{vec: 8'h5A, addr: 16'h0000, err: 1'b0});
    int86 = 1'b1;
    wait_for(0, 20, "bp_valid");
    repeat (5) begin
      @(negedge clock);
      chk("bp_vector", 32'(vec86), 32'h5A);
      chk("bp_valid_hold", 32'(v86), 1);
      chk("bp_no_pulse", 32'(inta86), 1);
    end
    pic_bytes[1] = 8'h6B;
    q86.push_back('{vec: 8'h6B, addr: 16'h0000, err: 1'b0});
    vector_ready = 1'b1;
    @(negedge clock);
    chk("bp_valid_drop", 32'(v86), 0);
    chk("bp_h0_inta", 32'(inta86), 1);
    @(negedge clock);
    chk("bp_h1_inta", 32'(inta86), 1);
    @(negedge clock);
    chk("bp_restart", 32'(inta86), 0);
    int86 = 1'b0;
    wait_for(1, 20, "bp_done");

    // reset during the second pulse
    @(negedge clock);
    vector_ready = 1'b0;
    pic_bytes[1] = 8'h77;
    int86 = 1'b1;
    repeat (6) @(negedge clock);
    chk("rp_pulse2_low", 32'(inta86), 0);
    reset = 1'b1;
    int86 = 1'b0;
    @(negedge clock);
    chk("rp_inta", 32'(inta86), 1);
    chk("rp_valid", 32'(v86), 0);
    chk("rp_busy", 32'(busy86), 0);
    reset = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (v86) saw = 1'b1;
    end
    chk("rp_no_deliver", 32'(saw), 0);
    chk("rp_vector", 32'(vec86), 0);

    // 8080 mode: good CALL, then bad opcode
    vector_ready = 1'b1;
    pic_bytes[0] = 8'hCD;
    pic_bytes[1] = 8'h20;
    pic_bytes[2] = 8'h40;
    q80.push_back('{vec: 8'hCD, addr: 16'h4020, err: 1'b0});
    int80 = 1'b1;
    wait_for(4, 10, "m80a_start");
    int80 = 1'b0;
    wait_for(3, 30, "m80a_done");
    @(negedge clock);
    pic_bytes[0] = 8'h00;
    pic_bytes[1] = 8'h11;
    pic_bytes[2] = 8'h22;
    q80.push_back('{vec: 8'h00, addr: 16'h2211, err: 1'b1});
    int80 = 1'b1;
    wait_for(4, 10, "m80b_start");
    int80 = 1'b0;
    wait_for(3, 30, "m80b_done");
    repeat (3) @(negedge clock);

    chk("sb86_drained", 32'(q86.size()), 0);
    chk("sb80_drained", 32'(q80.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
